branch_resolve_unit: RTL and testbench

//  Consumer side of the ALU flag path. Accepts one conditional branch at a time from the decode stage.

---
 rtl/branch_resolve_unit.sv | 165 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds one conditional branch until all in-flight
// flag writers have retired, evaluates it against {Z,V,N}, and on a taken
// branch issues a one-cycle PC redirect plus a multi-cycle IF/ID flush.
module branch_resolve_unit #(
  parameter int DATA_W    = 16,
  parameter int MAX_PEND  = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        flag_in,
  input  logic              fw_issue,
  input  logic              fw_retire,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] br_target,
  output logic              stall,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic              resolved,
  output logic              taken,
  output logic              pend_err
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int FC_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [PEND_W-1:0]   pend_reg, pend_next;
  logic                pend_err_reg, pend_err_next;
  logic [2:0]          cond_reg, cond_next;
  logic [DATA_W-1:0]   target_reg, target_next;
  logic [FC_W-1:0]     fcnt_reg, fcnt_next;
  logic                resolved_reg, resolved_next;
  logic                taken_reg, taken_next;
  logic                redirect_valid_reg, redirect_valid_next;
  logic [DATA_W-1:0]   redirect_pc_reg, redirect_pc_next;
  logic                flush_reg, flush_next;
  logic                stall_reg, br_ready_reg;
  logic                cond_true;

  // Pending flag-writer counter: saturates at both ends and flags the error.
  always_comb begin
    pend_next     = pend_reg;
    pend_err_next = pend_err_reg;
    if (fw_issue && !fw_retire) begin
      if (pend_reg == PEND_W'(MAX_PEND)) pend_err_next = 1'b1;
      else                               pend_next     = pend_reg + PEND_W'(1);
    end else if (fw_retire && !fw_issue) begin
      if (pend_reg == '0) pend_err_next = 1'b1;
      else                pend_next     = pend_reg - PEND_W'(1);
    end
  end

  // Condition evaluation against the live flag register output {Z,V,N}.
  always_comb begin
    cond_true = 1'b0;
    case (cond_reg)
      3'd0: cond_true = flag_in[2];
      3'd1: cond_true = ~flag_in[2];
      3'd2: cond_true = flag_in[0];
      3'd3: cond_true = ~flag_in[0];
      3'd4: cond_true = ~flag_in[0] & ~flag_in[2];
      3'd5: cond_true = flag_in[0] | flag_in[2];
      3'd6: cond_true = flag_in[1];
      3'd7: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_next          = state_reg;
    cond_next           = cond_reg;
    target_next         = target_reg;
    fcnt_next           = fcnt_reg;
    resolved_next       = 1'b0;
    taken_next          = 1'b0;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc_reg;
    flush_next          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (br_valid) begin
          cond_next   = br_cond;
          target_next = br_target;
          state_next  = (pend_next == '0) ? S_EVAL : S_WAIT;
        end
      end
      S_WAIT: begin
        // Uses the registered count, so a final retire still costs a cycle.
        if (pend_reg == '0) state_next = S_EVAL;
      end
      S_EVAL: begin
        resolved_next = 1'b1;
        taken_next    = cond_true;
        if (cond_true) begin
          redirect_valid_next = 1'b1;
          redirect_pc_next    = target_reg;
          flush_next          = 1'b1;
          fcnt_next           = '0;
          state_next          = S_FLUSH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (fcnt_reg == FC_W'(FLUSH_CYC - 1)) begin
          state_next = S_IDLE;
        end else begin
          fcnt_next  = fcnt_reg + FC_W'(1);
          flush_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any branch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= S_IDLE;
      pend_reg           <= '0;
      pend_err_reg       <= 1'b0;
      cond_reg           <= '0;
      target_reg         <= '0;
      fcnt_reg           <= '0;
      resolved_reg       <= 1'b0;
      taken_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      flush_reg          <= 1'b0;
      stall_reg          <= 1'b0;
      br_ready_reg       <= 1'b1;
    end else begin
      state_reg          <= state_next;
      pend_reg           <= pend_next;
      pend_err_reg       <= pend_err_next;
      cond_reg           <= cond_next;
      target_reg         <= target_next;
      fcnt_reg           <= fcnt_next;
      resolved_reg       <= resolved_next;
      taken_reg          <= taken_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
      flush_reg          <= flush_next;
      stall_reg          <= (state_next != S_IDLE);
      br_ready_reg       <= (state_next == S_IDLE);
    end
  end

  assign br_ready       = br_ready_reg;
  assign stall          = stall_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = flush_reg;
  assign resolved       = resolved_reg;
  assign taken          = taken_reg;
  assign pend_err       = pend_err_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: condition table sweep, hand-written
// multi-cycle sequences and a randomized run, all checked every cycle
// against a cycle-level behavioural model.
module tb_branch_resolve_unit;
  localparam int DATA_W    = 16;
  localparam int MAX_PEND  = 3;
  localparam int FLUSH_CYC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        flag_in = '0;
  logic              fw_issue = 1'b0, fw_retire = 1'b0, br_valid = 1'b0;
  logic [2:0]        br_cond = '0;
  logic [DATA_W-1:0] br_target = '0;
  logic              br_ready, stall, redirect_valid, flush, resolved, taken, pend_err;
  logic [DATA_W-1:0] redirect_pc;

  branch_resolve_unit #(.DATA_W(DATA_W), .MAX_PEND(MAX_PEND), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .flag_in(flag_in), .fw_issue(fw_issue), .fw_retire(fw_retire),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .resolved(resolved), .taken(taken), .pend_err(pend_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: a phase, a pending count and a flush countdown.
  localparam int M_IDLE = 0, M_WAIT = 1, M_EVAL = 2, M_FLUSH = 3;
  int                m_phase = M_IDLE, m_pend = 0, m_flush_left = 0, m_cond = 0;
  bit                m_err = 0, m_accept = 0, e_res = 0, e_taken = 0, e_redir = 0;
  logic [DATA_W-1:0] m_target = '0, e_pc = '0;

  typedef struct {
    logic [2:0] cond;
    logic [2:0] flags;
    bit         exp_taken;
  } vec_t;
  vec_t vecs[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input int c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      0: return z;
      1: return !z;
      2: return n;
      3: return !n;
      4: return !(n || z);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_edge();
    int pend_before;
    m_accept = 0;
    if (!rst) begin
      m_phase = M_IDLE; m_pend = 0; m_err = 0; m_flush_left = 0;
      e_res = 0; e_taken = 0; e_redir = 0; e_pc = '0;
      return;
    end
    pend_before = m_pend;
    if (fw_issue && !fw_retire) begin
      if (m_pend == MAX_PEND) m_err = 1; else m_pend++;
    end else if (fw_retire && !fw_issue) begin
      if (m_pend == 0) m_err = 1; else m_pend--;
    end
    e_res = 0; e_taken = 0; e_redir = 0;
    case (m_phase)
      M_IDLE: if (br_valid) begin
        m_accept = 1; m_cond = int'(br_cond); m_target = br_target;
        m_phase = (m_pend == 0) ? M_EVAL : M_WAIT;
      end
      M_WAIT: if (pend_before == 0) m_phase = M_EVAL;
      M_EVAL: begin
        e_res = 1;
        e_taken = cond_holds(m_cond, flag_in);
        if (e_taken) begin
          e_redir = 1; e_pc = m_target; m_flush_left = FLUSH_CYC; m_phase = M_FLUSH;
        end else begin
          m_phase = M_IDLE;
        end
      end
      default: begin
        m_flush_left--;
        if (m_flush_left == 0) m_phase = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("br_ready", 32'(br_ready), 32'(m_phase == M_IDLE));
    chk("stall", 32'(stall), 32'(m_phase != M_IDLE));
    chk("flush", 32'(flush), 32'(m_phase == M_FLUSH));
    chk("resolved", 32'(resolved), 32'(e_res));
    if (e_res) chk("taken", 32'(taken), 32'(e_taken));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    if (e_redir) chk("redirect_pc", 32'(redirect_pc), 32'(e_pc));
    chk("pend_err", 32'(pend_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12; i++) begin
      if (br_ready) break;
      step();
    end
    chk("idle_timeout", 32'(br_ready), 32'd1);
  endtask

  task automatic wait_resolved(output int cyc);
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      cyc++;
      if (resolved) break;
    end
    chk("resolve_timeout", 32'(resolved), 32'd1);
  endtask

  initial begin
    logic [3:0] masks[8];
    logic [2:0] pats[4];
    int         cyc, nred, first_red, second_red;

    // Expected taken per condition; bit k refers to flag pattern pats[k].
    pats[0] = 3'b000; pats[1] = 3'b100; pats[2] = 3'b010; pats[3] = 3'b001;
    masks[0] = 4'b0010; masks[1] = 4'b1101; masks[2] = 4'b1000; masks[3] = 4'b0111;
    masks[4] = 4'b0101; masks[5] = 4'b1010; masks[6] = 4'b0100; masks[7] = 4'b1111;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++)
        vecs[c*4+k] = '{cond: 3'(c), flags: pats[k], exp_taken: masks[c][k]};

    // Reset state
    rst = 1'b0;
    step(); step();
    chk("reset_ready", 32'(br_ready), 32'd1);
    rst = 1'b1;
    step();

    // Taken EQ branch with pend=0: one EVAL cycle, redirect, 2-cycle flush
    flag_in = 3'b100; br_cond = 3'd0; br_target = 16'h0040; br_valid = 1'b1;
    step();
    br_valid = 1'b0;
    chk("t2_eval_stall", 32'(stall), 32'd1);
    chk("t2_no_early_redirect", 32'(redirect_valid), 32'd0);
    step();
    chk("t2_redirect", 32'(redirect_valid), 32'd1);
    chk("t2_redirect_pc", 32'(redirect_pc), 32'h0040);
    chk("t2_flush1", 32'(flush), 32'd1);
    step();
    chk("t2_redirect_drop", 32'(redirect_valid), 32'd0);
    chk("t2_flush2", 32'(flush), 32'd1);
    step();
    chk("t2_flush_end", 32'(flush), 32'd0);
    chk("t2_ready", 32'(br_ready), 32'd1);

    // Two writers in flight hold an LT branch until both retire
    for (int pass = 0; pass < 2; pass++) begin
      fw_issue = 1'b1; step(); step(); fw_issue = 1'b0;
      flag_in = 3'b010; br_cond = 3'd2; br_target = 16'h0100 + 16'(pass); br_valid = 1'b1;
      step();
      br_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("t3_stall_hold", 32'(stall), 32'd1);
      end
      fw_retire = 1'b1; step(); step(); fw_retire = 1'b0;
      chk("t3_stall_after_retire", 32'(stall), 32'd1);
      flag_in = (pass == 0) ? 3'b001 : 3'b010;
      wait_resolved(cyc);
      chk("t3_last_wait_cycles", 32'(cyc), 32'd2);
      chk("t3_taken", 32'(taken), (pass == 0) ? 32'd1 : 32'd0);
      step();
      if (pass == 1) chk("t3_no_flush", 32'(flush), 32'd0);
      wait_idle();
    end

    // Condition table sweep
    for (int i = 0; i < 32; i++) begin
      flag_in = vecs[i].flags; br_cond = vecs[i].cond; br_target = 16'(16'h1000 + i);
      br_valid = 1'b1;
      step();
      br_valid = 1'b0;
      step();
      chk($sformatf("sweep_resolved_c%0d_f%0b", vecs[i].cond, vecs[i].flags), 32'(resolved), 32'd1);
      chk($sformatf("sweep_taken_c%0d_f%0b", vecs[i].cond, vecs[i].flags), 32'(taken), 32'(vecs[i].exp_taken));
      wait_idle();
    end

    // Counter corners: simultaneous issue+retire, overflow, underflow
    fw_issue = 1'b1; fw_retire = 1'b1; step();
    chk("t5_both_at_zero", 32'(pend_err), 32'd0);
    fw_retire = 1'b0; step();               // pend 1
    fw_retire = 1'b1; step();               // both: stays 1
    fw_retire = 1'b0; step(); step();       // pend 3
    chk("t5_no_err_at_max", 32'(pend_err), 32'd0);
    step();                                 // 4th issue saturates
    chk("t5_overflow_err", 32'(pend_err), 32'd1);
    fw_issue = 1'b0; fw_retire = 1'b1;
    step(); step(); step(); step();         // back to 0, then underflow
    fw_retire = 1'b0;
    chk("t5_err_sticky", 32'(pend_err), 32'd1);
    br_cond = 3'd7; br_valid = 1'b1; step(); br_valid = 1'b0;
    wait_resolved(cyc);
    chk("t5_pend_zero_latency", 32'(cyc), 32'd1);
    wait_idle();

    // Held br_valid through taken branches: one redirect per accept, 4 apart
    br_cond = 3'd7; br_target = 16'h2222; br_valid = 1'b1;
    nred = 0; first_red = -1; second_red = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (redirect_valid) begin
        nred++;
        if (first_red < 0) first_red = i; else if (second_red < 0) second_red = i;
      end
    end
    br_valid = 1'b0;
    chk("t6_redirect_count", 32'(nred), 32'd3);
    chk("t6_redirect_gap", 32'(second_red - first_red), 32'd4);
    wait_idle();

    // Reset mid-FLUSH with a writer pending abandons the branch
    br_cond = 3'd7; br_target = 16'h3333; br_valid = 1'b1; step(); br_valid = 1'b0;
    step();
    fw_issue = 1'b1; step(); fw_issue = 1'b0;
    chk("t1_in_flush", 32'(flush), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_async_ready", 32'(br_ready), 32'd1);
    chk("t1_async_flush", 32'(flush), 32'd0);
    chk("t1_async_err", 32'(pend_err), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("t1_no_redirect", 32'(redirect_valid), 32'd0);
    br_valid = 1'b1; step(); br_valid = 1'b0;
    wait_resolved(cyc);
    chk("t1_pend_cleared", 32'(cyc), 32'd1);
    wait_idle();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      fw_issue  = ($urandom_range(0, 3) == 0);
      fw_retire = ($urandom_range(0, 3) == 0);
      flag_in   = 3'($urandom);
      rst       = ($urandom_range(0, 299) != 0);
      if (!br_valid && $urandom_range(0, 2) == 0) begin
        br_valid = 1'b1; br_cond = 3'($urandom); br_target = 16'($urandom);
      end
      step();
      if (m_accept) br_valid = 1'b0;
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
